// File: rtl/eth_hdr_parser_arbiter.sv
// Shares one Ethernet header parser between two AXI-Stream ports: round-robin
// frame arbitration, header buffering, bubble-free burst to the parser, tagged result.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no frame owned; arbitrate between s0/s1 requests
// COLLECT  | accept header beats of granted port into the buffer
// DRAIN    | header buffered; consume and discard payload up to tlast
// BURST    | replay buffered header beats to the parser back-to-back
// WAIT_HDR | wait for parser result, bounded by HDR_TIMEOUT cycles
// HOLD     | present tagged header until downstream accepts it
module eth_hdr_parser_arbiter #(
  parameter int HDR_BEATS   = 3,
  parameter int HDR_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [63:0]      s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [63:0]      s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [63:0]      p_tdata,
  output logic             p_tvalid,
  input  logic             p_valid,
  input  logic [47:0]      p_dst_mac,
  input  logic [47:0]      p_src_mac,
  input  logic [15:0]      p_eth_type,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic             hdr_port,
  output logic [47:0]      hdr_dst_mac,
  output logic [47:0]      hdr_src_mac,
  output logic [15:0]      hdr_eth_type,
  output logic [CNT_W-1:0] runt_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int IW = $clog2(HDR_BEATS);
  localparam int TW = $clog2(HDR_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, BURST, WAIT_HDR, HOLD} state_t;

  state_t        state, state_nxt;
  logic          grant, last_grant, grant_nxt;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo;
  logic [63:0]   hbuf [HDR_BEATS];
  logic [63:0]   g_tdata;
  logic          g_tvalid, g_tlast, g_tready, beat_acc, idx_last;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = (s0_tvalid & s1_tvalid) ? ~last_grant : s1_tvalid;
    g_tdata   = grant ? s1_tdata  : s0_tdata;
    g_tvalid  = grant ? s1_tvalid : s0_tvalid;
    g_tlast   = grant ? s1_tlast  : s0_tlast;
    g_tready  = (state == COLLECT) || (state == DRAIN);
    beat_acc  = g_tready & g_tvalid;
    idx_last  = (idx == IW'(HDR_BEATS - 1));
    s0_tready = g_tready & ~grant;
    s1_tready = g_tready & grant;
    p_tvalid  = (state == BURST);
    p_tdata   = p_tvalid ? hbuf[idx] : '0;
    hdr_valid = (state == HOLD);
    case (state)
      IDLE:     if (s0_tvalid | s1_tvalid) state_nxt = COLLECT;
      COLLECT:  if (beat_acc) begin
                  if (idx_last)     state_nxt = g_tlast ? BURST : DRAIN;
                  else if (g_tlast) state_nxt = IDLE;
                end
      DRAIN:    if (beat_acc && g_tlast) state_nxt = BURST;
      BURST:    if (idx_last) state_nxt = WAIT_HDR;
      WAIT_HDR: if (p_valid) state_nxt = HOLD;
                else if (tmo == '0) state_nxt = IDLE;
      HOLD:     if (hdr_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // idx is the buffer write pointer in COLLECT and the read pointer in BURST
  always_ff @(posedge clk) begin
    if (clear) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      idx          <= '0;
      tmo          <= '0;
      runt_cnt     <= '0;
      timeout_cnt  <= '0;
      hdr_port     <= 1'b0;
      hdr_dst_mac  <= '0;
      hdr_src_mac  <= '0;
      hdr_eth_type <= '0;
    end else begin
      case (state)
        IDLE: if (s0_tvalid | s1_tvalid) begin
          grant      <= grant_nxt;
          last_grant <= grant_nxt;
          idx        <= '0;
        end
        COLLECT: if (beat_acc) begin
          if (idx_last || g_tlast) idx <= '0;
          else                     idx <= idx + 1'b1;
          if (g_tlast && !idx_last && runt_cnt != '1) runt_cnt <= runt_cnt + 1'b1;
        end
        BURST: begin
          idx <= idx_last ? '0 : idx + 1'b1;
          tmo <= TW'(HDR_TIMEOUT - 1);
        end
        WAIT_HDR: begin
          if (p_valid) begin
            hdr_port     <= grant;
            hdr_dst_mac  <= p_dst_mac;
            hdr_src_mac  <= p_src_mac;
            hdr_eth_type <= p_eth_type;
          end else if (tmo == '0) begin
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == COLLECT && beat_acc) hbuf[idx] <= g_tdata;
  end

endmodule

// File: tb/tb_eth_hdr_parser_arbiter.sv
// Directed bench for eth_hdr_parser_arbiter: parser model derives header fields
// from the burst beats; expected headers are queued when frames are driven.
module tb_eth_hdr_parser_arbiter;
  localparam int HB = 3;
  localparam int HT = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clear;
  logic [63:0]   s0_tdata, s1_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic [63:0]   p_tdata;
  logic          p_tvalid;
  logic          p_valid = 1'b0;
  logic [47:0]   p_dst_mac = '0;
  logic [47:0]   p_src_mac = '0;
  logic [15:0]   p_eth_type = '0;
  logic          hdr_valid, hdr_ready, hdr_port;
  logic [47:0]   hdr_dst_mac, hdr_src_mac;
  logic [15:0]   hdr_eth_type;
  logic [CW-1:0] runt_cnt, timeout_cnt;

  eth_hdr_parser_arbiter #(.HDR_BEATS(HB), .HDR_TIMEOUT(HT), .CNT_W(CW)) dut (
    .clk(clk), .clear(clear),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .p_tdata(p_tdata), .p_tvalid(p_tvalid), .p_valid(p_valid),
    .p_dst_mac(p_dst_mac), .p_src_mac(p_src_mac), .p_eth_type(p_eth_type),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_port(hdr_port),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac), .hdr_eth_type(hdr_eth_type),
    .runt_cnt(runt_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
  } hdr_t;

  hdr_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   hs_cnt = 0;
  int   nbursts = 0;
  bit   pm_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic hdr_t exp_hdr(input logic port, input logic [63:0] base);
    logic [63:0] b1, b2;
    hdr_t h;
    b1 = base + 64'd1;
    b2 = base + 64'd2;
    h.port = port;
    h.dst  = base[47:0];
    h.src  = b1[47:0];
    h.et   = b2[15:0];
    return h;
  endfunction

  // Parser model: dst/src/type taken from beats 0/1/2, result one cycle after WAIT_HDR entry
  logic [63:0] pbeat [0:3];
  int  pcnt = 0;
  bit  pend = 1'b0;
  always @(negedge clk) begin
    if (p_valid) begin
      p_valid = 1'b0; p_dst_mac = '0; p_src_mac = '0; p_eth_type = '0;
    end
    if (pend) begin
      pend = 1'b0;
      if (pm_en) begin
        p_valid    = 1'b1;
        p_dst_mac  = pbeat[0][47:0];
        p_src_mac  = pbeat[1][47:0];
        p_eth_type = pbeat[2][15:0];
      end
    end
    if (p_tvalid) begin
      if (pcnt < 4) pbeat[pcnt] = p_tdata;
      pcnt++;
    end else begin
      chk("p_tdata_idle", p_tdata, 64'd0);
      if (pcnt > 0) begin
        chk("burst_len", pcnt, HB);
        nbursts++;
        pend = 1'b1;
        pcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!clear) begin
      if (hdr_valid) begin
        if (sb.size() == 0) chk("hdr_unexpected", hdr_valid, 1'b0);
        else begin
          chk("hdr_port", hdr_port, sb[0].port);
          chk("hdr_dst", hdr_dst_mac, sb[0].dst);
          chk("hdr_src", hdr_src_mac, sb[0].src);
          chk("hdr_type", hdr_eth_type, sb[0].et);
          if (hdr_ready) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
      if ((s0_tready || s1_tready) && sb.size() > 0) begin
        chk("grant_s0_tready", s0_tready, !sb[0].port);
        chk("grant_s1_tready", s1_tready, sb[0].port);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input bit port, input logic v, input logic [63:0] d, input logic l);
    if (port) begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
    else      begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
  endtask

  task automatic drive_port(input bit port, input int n, input logic [63:0] base, input int gap_mask);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      if (gap_mask[i]) begin
        set_port(port, 1'b0, 64'd0, 1'b0);
        tick();
      end
      set_port(port, 1'b1, base + 64'(i), i == n - 1);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = port ? s1_tready : s0_tready;
        tick();
        t++;
      end
      chk("drv_accept", acc, 1'b1);
    end
    set_port(port, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic wait_sb_empty(input int bound);
    int t = 0;
    while (sb.size() != 0 && t < bound) begin
      tick();
      t++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_s0_tready"}, s0_tready, 0);
    chk({pfx, "_s1_tready"}, s1_tready, 0);
    chk({pfx, "_p_tvalid"}, p_tvalid, 0);
    chk({pfx, "_p_tdata"}, p_tdata, 0);
    chk({pfx, "_hdr_valid"}, hdr_valid, 0);
    chk({pfx, "_hdr_port"}, hdr_port, 0);
    chk({pfx, "_hdr_dst"}, hdr_dst_mac, 0);
    chk({pfx, "_hdr_src"}, hdr_src_mac, 0);
    chk({pfx, "_hdr_type"}, hdr_eth_type, 0);
    chk({pfx, "_runt_cnt"}, runt_cnt, 0);
    chk({pfx, "_timeout_cnt"}, timeout_cnt, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b1 [0:2];
    int hs0, nb0, t;
    bit exp_tv;

    clear = 1'b1; hdr_ready = 1'b1;
    s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_zero("rst");
    tick();

    // Nominal cycle-exact frame on port 0
    for (int i = 0; i < 3; i++) b1[i] = 64'hA5A5_0011_2233_4455 + 64'(i);
    sb.push_back(exp_hdr(1'b0, b1[0]));
    clear = 1'b0;
    set_port(1'b0, 1'b1, b1[0], 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_tv = (k >= 4 && k <= 6);
      chk("t1_p_tvalid", p_tvalid, exp_tv);
      if (exp_tv) chk("t1_p_tdata", p_tdata, b1[k-4]);
      chk("t1_hdr_valid", hdr_valid, k == 9);
      chk("t1_s0_tready", s0_tready, k >= 1 && k <= 3);
      chk("t1_s1_tready", s1_tready, 1'b0);
      if (k == 9) begin
        chk("t1_hdr_port", hdr_port, 1'b0);
        chk("t1_hdr_dst", hdr_dst_mac, 48'h0011_2233_4455);
      end
      tick();
      if (k + 1 == 2) set_port(1'b0, 1'b1, b1[1], 1'b0);
      if (k + 1 == 3) set_port(1'b0, 1'b1, b1[2], 1'b1);
      if (k + 1 == 4) set_port(1'b0, 1'b0, 64'd0, 1'b0);
    end

    // Round-robin with both ports requesting out of reset
    do_clear();
    hs0 = hs_cnt;
    sb.push_back(exp_hdr(1'b0, 64'h1000_0000_0000_0100));
    sb.push_back(exp_hdr(1'b1, 64'h2000_0000_0000_0200));
    sb.push_back(exp_hdr(1'b0, 64'h3000_0000_0000_0300));
    fork
      begin
        drive_port(1'b0, 3, 64'h1000_0000_0000_0100, 0);
        drive_port(1'b0, 3, 64'h3000_0000_0000_0300, 0);
      end
      drive_port(1'b1, 3, 64'h2000_0000_0000_0200, 0);
    join
    wait_sb_empty(100);
    chk("rr_handshakes", hs_cnt - hs0, 3);

    // Long frame with tvalid gaps inside the header beats
    hs0 = hs_cnt; nb0 = nbursts;
    sb.push_back(exp_hdr(1'b1, 64'h4444_5555_6666_7700));
    drive_port(1'b1, 6, 64'h4444_5555_6666_7700, 32'h6);
    wait_sb_empty(100);
    chk("gap_handshakes", hs_cnt - hs0, 1);
    chk("gap_bursts", nbursts - nb0, 1);

    // Runt followed by a normal frame
    hs0 = hs_cnt; nb0 = nbursts;
    drive_port(1'b0, 2, 64'h0BAD_0000_0000_0000, 0);
    @(negedge clk);
    chk("runt_cnt", runt_cnt, 1);
    repeat (6) tick();
    chk("runt_no_burst", nbursts - nb0, 0);
    chk("runt_no_hdr", hs_cnt - hs0, 0);
    sb.push_back(exp_hdr(1'b0, 64'h5555_0000_AAAA_0800));
    drive_port(1'b0, 3, 64'h5555_0000_AAAA_0800, 0);
    wait_sb_empty(100);
    chk("post_runt_hdr", hs_cnt - hs0, 1);

    // Parser silent: timeout after HT cycles in WAIT_HDR
    pm_en = 1'b0;
    drive_port(1'b0, 3, 64'h7777_0000_0000_0000, 0);
    for (int k = 4; k <= 15; k++) begin
      @(negedge clk);
      chk("tmo_hdr_valid", hdr_valid, 1'b0);
      chk("tmo_cnt", timeout_cnt, (k == 15) ? 1 : 0);
      tick();
    end
    pm_en = 1'b1;
    chk("tmo_runt_kept", runt_cnt, 1);

    // HOLD with backpressure while port 1 requests, then clear mid-COLLECT
    hdr_ready = 1'b0;
    sb.push_back(exp_hdr(1'b0, 64'h8888_1234_5678_9A00));
    drive_port(1'b0, 3, 64'h8888_1234_5678_9A00, 0);
    set_port(1'b1, 1'b1, 64'hCAFE_0000_0000_0001, 1'b0);
    t = 0;
    @(negedge clk);
    while (!hdr_valid && t < 50) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("hold_wait_hdr", hdr_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_hdr_valid", hdr_valid, 1'b1);
      chk("hold_s1_tready", s1_tready, 1'b0);
      tick();
    end
    hdr_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s1_tready && t < 50) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("hold_s1_granted", s1_tready, 1'b1);
    chk("hold_sb_empty", sb.size(), 0);
    tick();
    clear = 1'b1;
    set_port(1'b1, 1'b0, 64'd0, 1'b0);
    tick();
    @(negedge clk);
    chk_zero("clr");
    tick();
    clear = 1'b0;

    // After clear, port 0 wins the tie again
    hs0 = hs_cnt;
    sb.push_back(exp_hdr(1'b0, 64'h9999_0000_0000_0010));
    sb.push_back(exp_hdr(1'b1, 64'hAAAA_0000_0000_0020));
    fork
      drive_port(1'b0, 3, 64'h9999_0000_0000_0010, 0);
      drive_port(1'b1, 4, 64'hAAAA_0000_0000_0020, 0);
    join
    wait_sb_empty(100);
    chk("post_clr_handshakes", hs_cnt - hs0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
